elevator_scheduler: RTL and testbench



---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_look_pick.sv | 26 ++
 rtl/elevator_scheduler.sv | 167 ++++++++++++++++
 tb/tb_elevator_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car scheduler.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

endpackage

// File: rtl/elevator_look_pick.sv
// Classifies outstanding requests relative to the car: above, below, or at the current floor.
module elevator_look_pick #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  output logic                  any_above_o,
  output logic                  any_below_o,
  output logic                  hit_here_o
);

  always_comb begin
    any_above_o = 1'b0;
    any_below_o = 1'b0;
    hit_here_o  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[i]) begin
        if (i > int'(floor_i)) any_above_o = 1'b1;
        if (i < int'(floor_i)) any_below_o = 1'b1;
        if (i == int'(floor_i)) hit_here_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Car controller: request bitmap, LOOK stop selection, floor stepping, door timer and weight interlock.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int RESET_FLOOR   = 1,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6,
  parameter int WEIGHT_W      = 11,
  parameter int WEIGHT_LIMIT  = 899
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [WEIGHT_W-1:0]   weight,
  output logic [FLOOR_W-1:0]    out_floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic                  complete,
  output logic                  over_weight,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMR_MAX   = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int TRAVEL_M1 = TRAVEL_CYCLES - 1;
  localparam int DOOR_M1   = DOOR_CYCLES - 1;
  localparam int TOP_INT   = NUM_FLOORS - 1;

  localparam logic [TMR_W-1:0]    TRAVEL_LOAD = TRAVEL_M1[TMR_W-1:0];
  localparam logic [TMR_W-1:0]    DOOR_LOAD   = DOOR_M1[TMR_W-1:0];
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = TOP_INT[FLOOR_W-1:0];
  localparam logic [FLOOR_W-1:0]  RST_FLOOR   = RESET_FLOOR[FLOOR_W-1:0];
  localparam logic [FLOOR_W:0]    NF_LIM      = NUM_FLOORS[FLOOR_W:0];
  localparam logic [WEIGHT_W-1:0] W_LIM       = WEIGHT_LIMIT[WEIGHT_W-1:0];

  state_e                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic [1:0]              dir_q, dir_d;
  logic                    pref_up_q, pref_up_d;
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic                    comp_q, comp_d;
  logic                    ow_q;

  logic                    any_above, any_below, hit_here;
  logic                    req_ok, req_here, ahead, behind, go_up;
  logic [FLOOR_W-1:0]      step_floor;

  elevator_look_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_pick (
    .pending_i   (pend_q),
    .floor_i     (floor_q),
    .any_above_o (any_above),
    .any_below_o (any_below),
    .hit_here_o  (hit_here)
  );

  always_comb begin
    req_ok   = req_valid && ({1'b0, req_floor} < NF_LIM);
    req_here = req_ok && (req_floor == floor_q) && (state_q != MOVE);
    ahead    = pref_up_q ? any_above : any_below;
    behind   = pref_up_q ? any_below : any_above;
    go_up    = pref_up_q ? any_above : !any_below;
    if (dir_q == DIR_UP) step_floor = (floor_q < TOP_FLOOR) ? floor_q + 1'b1 : floor_q;
    else                 step_floor = (floor_q != '0) ? floor_q - 1'b1 : floor_q;
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pref_up_d = pref_up_q;
    tmr_d     = tmr_q;
    pend_d    = pend_q;
    comp_d    = 1'b0;

    // Service clears are applied after intake so an arrival absorbs a same-cycle request.
    if (req_ok && !req_here) pend_d[req_floor] = 1'b1;

    case (state_q)
      IDLE: begin
        dir_d = DIR_IDLE;
        if (req_here || hit_here) begin
          pend_d[floor_q] = 1'b0;
          state_d         = DOOR;
          tmr_d           = DOOR_LOAD;
          comp_d          = 1'b1;
        end else if (|pend_q) begin
          dir_d     = go_up ? DIR_UP : DIR_DOWN;
          pref_up_d = go_up;
          state_d   = MOVE;
          tmr_d     = TRAVEL_LOAD;
        end
      end
      MOVE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else begin
          floor_d = step_floor;
          if (pend_q[step_floor]) begin
            pend_d[step_floor] = 1'b0;
            state_d            = DOOR;
            tmr_d              = DOOR_LOAD;
            comp_d             = 1'b1;
          end else begin
            tmr_d = TRAVEL_LOAD;
          end
        end
      end
      DOOR: begin
        if (req_here || ow_q) begin
          tmr_d = DOOR_LOAD;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (ahead) begin
          state_d = MOVE;
          tmr_d   = TRAVEL_LOAD;
          dir_d   = pref_up_q ? DIR_UP : DIR_DOWN;
        end else if (behind) begin
          state_d   = MOVE;
          tmr_d     = TRAVEL_LOAD;
          dir_d     = pref_up_q ? DIR_DOWN : DIR_UP;
          pref_up_d = !pref_up_q;
        end else begin
          state_d = IDLE;
          dir_d   = DIR_IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      floor_q   <= RST_FLOOR;
      dir_q     <= DIR_IDLE;
      pref_up_q <= 1'b1;
      tmr_q     <= '0;
      pend_q    <= '0;
      comp_q    <= 1'b0;
      ow_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      pref_up_q <= pref_up_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      comp_q    <= comp_d;
      ow_q      <= (weight > W_LIM);
    end
  end

  assign out_floor   = floor_q;
  assign direction   = dir_q;
  assign door_open   = (state_q == DOOR);
  assign complete    = comp_q;
  assign over_weight = ow_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized traffic against a rule-level car model.
module tb_elevator_scheduler;

  localparam int TRAVEL_N = 4;
  localparam int DOOR_N   = 6;
  localparam int M_IDLE   = 0;
  localparam int M_MOVE   = 1;
  localparam int M_DOOR   = 2;
  localparam int UP       = 1;
  localparam int DN       = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_floor = 3'd0;
  logic [10:0] weight = 11'd0;

  logic [2:0] o8_floor;  logic [1:0] o8_dir;  logic o8_door, o8_comp, o8_ow;  logic [7:0] o8_pend;
  logic [2:0] o6_floor;  logic [1:0] o6_dir;  logic o6_door, o6_comp, o6_ow;  logic [5:0] o6_pend;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  elevator_scheduler dut8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor), .weight(weight),
    .out_floor(o8_floor), .direction(o8_dir), .door_open(o8_door), .complete(o8_comp),
    .over_weight(o8_ow), .pending(o8_pend)
  );

  elevator_scheduler #(.NUM_FLOORS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor), .weight(weight),
    .out_floor(o6_floor), .direction(o6_dir), .door_open(o6_door), .complete(o6_comp),
    .over_weight(o6_ow), .pending(o6_pend)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    int         mode;
    int         tmr;
    int         pref;
    logic [2:0] floor;
    logic [1:0] dir;
    logic [7:0] pend;
    logic       ow;
    logic       comp;
  } mdl_t;

  mdl_t m8, m6;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = M_IDLE; r.tmr = 0; r.pref = UP; r.floor = 3'd1; r.dir = 2'd0;
    r.pend = 8'h00; r.ow = 1'b0; r.comp = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic rv, input logic [2:0] rf,
                                 input logic [10:0] w, input int nf);
    mdl_t n;
    bit above, below, accept, here, ahead, behind;
    int f, nxt;
    n = m;
    n.comp = 1'b0;
    n.ow = (int'(w) > 899);
    f = int'(m.floor);
    above = 0; below = 0;
    for (int i = 0; i < nf; i++) begin
      if (m.pend[i] && i > f) above = 1;
      if (m.pend[i] && i < f) below = 1;
    end
    accept = rv && (int'(rf) < nf);
    here = accept && (rf == m.floor) && (m.mode != M_MOVE);
    if (accept && !here) n.pend[rf] = 1'b1;
    if (m.mode == M_IDLE) begin
      if (here) begin
        n.mode = M_DOOR; n.tmr = DOOR_N - 1; n.comp = 1'b1;
      end else if (m.pend != 8'h00) begin
        if (m.pref == UP) n.pref = above ? UP : DN;
        else              n.pref = below ? DN : UP;
        n.dir = 2'(n.pref); n.mode = M_MOVE; n.tmr = TRAVEL_N - 1;
      end
    end else if (m.mode == M_MOVE) begin
      if (m.tmr > 0) begin
        n.tmr = m.tmr - 1;
      end else begin
        nxt = (m.dir == 2'd1) ? f + 1 : f - 1;
        if (nxt > nf - 1) nxt = nf - 1;
        if (nxt < 0) nxt = 0;
        n.floor = 3'(nxt);
        if (m.pend[nxt]) begin
          n.pend[nxt] = 1'b0; n.mode = M_DOOR; n.tmr = DOOR_N - 1; n.comp = 1'b1;
        end else begin
          n.tmr = TRAVEL_N - 1;
        end
      end
    end else begin
      ahead  = (m.pref == UP) ? above : below;
      behind = (m.pref == UP) ? below : above;
      if (here || m.ow) n.tmr = DOOR_N - 1;
      else if (m.tmr > 0) n.tmr = m.tmr - 1;
      else if (ahead) begin
        n.mode = M_MOVE; n.tmr = TRAVEL_N - 1; n.dir = 2'(m.pref);
      end else if (behind) begin
        n.pref = (m.pref == UP) ? DN : UP;
        n.mode = M_MOVE; n.tmr = TRAVEL_N - 1; n.dir = 2'(n.pref);
      end else begin
        n.mode = M_IDLE; n.dir = 2'd0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= mreset();
      m6 <= mreset();
    end else begin
      m8 <= mstep(m8, req_valid, req_floor, weight, 8);
      m6 <= mstep(m6, req_valid, req_floor, weight, 6);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_floor = 3'd0; weight = 11'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_req(input logic [2:0] f);
    req_valid = 1'b1; req_floor = f;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (o8_floor !== 3'd1) begin fails++; $display("FAIL reset_floor: got %0d want 1", o8_floor); end
    checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL reset_dir: got %0d want 0", o8_dir); end
    checks++; if (o8_door !== 1'b0) begin fails++; $display("FAIL reset_door: got %0b want 0", o8_door); end
    checks++; if (o8_comp !== 1'b0) begin fails++; $display("FAIL reset_complete: got %0b want 0", o8_comp); end
    checks++; if (o8_ow !== 1'b0) begin fails++; $display("FAIL reset_ow: got %0b want 0", o8_ow); end
    checks++; if (o8_pend !== 8'h00) begin fails++; $display("FAIL reset_pending: got %0h want 0", o8_pend); end
  endtask

  task automatic test_single_up();
    int ef;
    do_reset();
    send_req(3'd5);
    checks++; if (o8_pend !== 8'h20) begin fails++; $display("FAIL up_pending: got %0h want 20", o8_pend); end
    checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL up_dir_lat: got %0d want 0", o8_dir); end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ef = 1 + (k - 1) / TRAVEL_N;
      if (ef > 5) ef = 5;
      checks++; if (int'(o8_floor) != ef) begin fails++; $display("FAIL up_floor k=%0d: got %0d want %0d", k, o8_floor, ef); end
      checks++; if (o8_comp !== (k == 17)) begin fails++; $display("FAIL up_complete k=%0d: got %0b want %0b", k, o8_comp, (k == 17)); end
      checks++; if (o8_door !== (k >= 17 && k <= 22)) begin fails++; $display("FAIL up_door k=%0d: got %0b", k, o8_door); end
      if (k <= 16) begin
        checks++; if (o8_dir !== 2'd1) begin fails++; $display("FAIL up_dir k=%0d: got %0d want 1", k, o8_dir); end
      end
      if (k >= 23) begin
        checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL up_idle_dir k=%0d: got %0d want 0", k, o8_dir); end
        checks++; if (o8_pend !== 8'h00) begin fails++; $display("FAIL up_idle_pend k=%0d: got %0h want 0", k, o8_pend); end
      end
    end
  endtask

  task automatic test_sweep();
    int cf[$];
    int cd[$];
    bit ok;
    do_reset();
    send_req(3'd3);
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (o8_floor == 3'd3 && o8_dir == 2'd0 && !o8_door) ok = 1;
    end
    checks++; if (!ok) begin fails++; $display("FAIL sweep_reach3: floor %0d want idle at 3", o8_floor); end
    send_req(3'd6);
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (o8_floor == 3'd4) ok = 1;
    end
    checks++; if (!ok) begin fails++; $display("FAIL sweep_reach4: floor %0d want 4", o8_floor); end
    send_req(3'd5);
    send_req(3'd1);
    for (int k = 0; k < 200 && cf.size() < 3; k++) begin
      if (o8_comp) begin cf.push_back(int'(o8_floor)); cd.push_back(int'(o8_dir)); end
      @(negedge clk);
    end
    checks++; if (cf.size() != 3) begin fails++; $display("FAIL sweep_count: got %0d want 3", cf.size()); end
    if (cf.size() == 3) begin
      checks++; if (cf[0] != 5) begin fails++; $display("FAIL sweep_stop0: got %0d want 5", cf[0]); end
      checks++; if (cf[1] != 6) begin fails++; $display("FAIL sweep_stop1: got %0d want 6", cf[1]); end
      checks++; if (cf[2] != 1) begin fails++; $display("FAIL sweep_stop2: got %0d want 1", cf[2]); end
      checks++; if (cd[1] != 1) begin fails++; $display("FAIL sweep_dir_up: got %0d want 1", cd[1]); end
      checks++; if (cd[2] != 2) begin fails++; $display("FAIL sweep_dir_down: got %0d want 2", cd[2]); end
    end
  endtask

  task automatic test_overweight();
    bit ok;
    int closed_at;
    do_reset();
    send_req(3'd2);
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (o8_door) ok = 1;
    end
    checks++; if (!ok) begin fails++; $display("FAIL ow_door_open: door %0b want 1", o8_door); end
    weight = 11'd900;
    checks++; if (o8_ow !== 1'b0) begin fails++; $display("FAIL ow_latency_pre: got %0b want 0", o8_ow); end
    @(negedge clk);
    checks++; if (o8_ow !== 1'b1) begin fails++; $display("FAIL ow_set: got %0b want 1", o8_ow); end
    send_req(3'd4);
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      checks++; if (o8_door !== 1'b1) begin fails++; $display("FAIL ow_hold_door k=%0d: got %0b want 1", k, o8_door); end
      checks++; if (o8_floor !== 3'd2) begin fails++; $display("FAIL ow_hold_floor k=%0d: got %0d want 2", k, o8_floor); end
    end
    weight = 11'd899;
    closed_at = -1;
    for (int k = 1; k <= 12 && closed_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checks++; if (o8_ow !== 1'b0) begin fails++; $display("FAIL ow_clear: got %0b want 0", o8_ow); end
      end
      if (!o8_door) closed_at = k;
    end
    checks++; if (closed_at != 7) begin fails++; $display("FAIL ow_close_delay: got %0d want 7", closed_at); end
    checks++; if (o8_dir !== 2'd1) begin fails++; $display("FAIL ow_depart_dir: got %0d want 1", o8_dir); end
  endtask

  task automatic test_same_floor();
    do_reset();
    send_req(3'd1);
    checks++; if (o8_door !== 1'b1) begin fails++; $display("FAIL here_door: got %0b want 1", o8_door); end
    checks++; if (o8_comp !== 1'b1) begin fails++; $display("FAIL here_complete: got %0b want 1", o8_comp); end
    checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL here_dir: got %0d want 0", o8_dir); end
    checks++; if (o8_pend !== 8'h00) begin fails++; $display("FAIL here_pend: got %0h want 0", o8_pend); end
    @(negedge clk);
    checks++; if (o8_comp !== 1'b0) begin fails++; $display("FAIL here_pulse_width: got %0b want 0", o8_comp); end
    @(negedge clk);
    send_req(3'd1);
    checks++; if (o8_pend !== 8'h00) begin fails++; $display("FAIL here_repeat_pend: got %0h want 0", o8_pend); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++; if (o8_door !== (k <= 5)) begin fails++; $display("FAIL here_extend k=%0d: got %0b want %0b", k, o8_door, (k <= 5)); end
    end
    checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL here_after_dir: got %0d want 0", o8_dir); end
  endtask

  task automatic test_bounds();
    bit seen5;
    do_reset();
    send_req(3'd7);
    checks++; if (o6_pend !== 6'h00) begin fails++; $display("FAIL nf6_ignore7: got %0h want 0", o6_pend); end
    checks++; if (o8_pend !== 8'h80) begin fails++; $display("FAIL nf8_accept7: got %0h want 80", o8_pend); end
    send_req(3'd6);
    checks++; if (o6_pend !== 6'h00) begin fails++; $display("FAIL nf6_ignore6: got %0h want 0", o6_pend); end
    send_req(3'd5);
    checks++; if (o6_pend !== 6'h20) begin fails++; $display("FAIL nf6_accept5: got %0h want 20", o6_pend); end
    seen5 = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      checks++; if (o6_floor > 3'd5) begin fails++; $display("FAIL nf6_range k=%0d: got %0d max 5", k, o6_floor); end
      if (o6_comp && o6_floor == 3'd5) seen5 = 1;
    end
    checks++; if (!seen5) begin fails++; $display("FAIL nf6_serve5: got floor %0d want arrival at 5", o6_floor); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    send_req(3'd4);
    send_req(3'd7);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (o8_floor == 3'd2) ok = 1;
    end
    checks++; if (!ok) begin fails++; $display("FAIL arst_reach2: floor %0d want 2", o8_floor); end
    checks++; if (o8_pend !== 8'h90) begin fails++; $display("FAIL arst_pre_pend: got %0h want 90", o8_pend); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o8_floor !== 3'd1) begin fails++; $display("FAIL arst_floor: got %0d want 1", o8_floor); end
    checks++; if (o8_dir !== 2'd0) begin fails++; $display("FAIL arst_dir: got %0d want 0", o8_dir); end
    checks++; if (o8_pend !== 8'h00) begin fails++; $display("FAIL arst_pend: got %0h want 0", o8_pend); end
    checks++; if (o8_door !== 1'b0) begin fails++; $display("FAIL arst_door: got %0b want 0", o8_door); end
    @(negedge clk);
    rst_n = 1'b1;
    send_req(3'd3);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (o8_comp && o8_floor == 3'd3) ok = 1;
    end
    checks++; if (!ok) begin fails++; $display("FAIL arst_resume: floor %0d want arrival at 3", o8_floor); end
  endtask

  task automatic test_random();
    bit heavy;
    do_reset();
    heavy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++; if (o8_floor !== m8.floor) begin fails++; $display("FAIL rnd8_floor c=%0d: got %0d want %0d", c, o8_floor, m8.floor); end
      checks++; if (o8_dir !== m8.dir) begin fails++; $display("FAIL rnd8_dir c=%0d: got %0d want %0d", c, o8_dir, m8.dir); end
      checks++; if (o8_door !== (m8.mode == M_DOOR)) begin fails++; $display("FAIL rnd8_door c=%0d: got %0b want %0b", c, o8_door, (m8.mode == M_DOOR)); end
      checks++; if (o8_comp !== m8.comp) begin fails++; $display("FAIL rnd8_complete c=%0d: got %0b want %0b", c, o8_comp, m8.comp); end
      checks++; if (o8_ow !== m8.ow) begin fails++; $display("FAIL rnd8_ow c=%0d: got %0b want %0b", c, o8_ow, m8.ow); end
      checks++; if (o8_pend !== m8.pend) begin fails++; $display("FAIL rnd8_pend c=%0d: got %0h want %0h", c, o8_pend, m8.pend); end
      checks++; if (o6_floor !== m6.floor) begin fails++; $display("FAIL rnd6_floor c=%0d: got %0d want %0d", c, o6_floor, m6.floor); end
      checks++; if (o6_dir !== m6.dir) begin fails++; $display("FAIL rnd6_dir c=%0d: got %0d want %0d", c, o6_dir, m6.dir); end
      checks++; if (o6_door !== (m6.mode == M_DOOR)) begin fails++; $display("FAIL rnd6_door c=%0d: got %0b want %0b", c, o6_door, (m6.mode == M_DOOR)); end
      checks++; if (o6_comp !== m6.comp) begin fails++; $display("FAIL rnd6_complete c=%0d: got %0b want %0b", c, o6_comp, m6.comp); end
      checks++; if (o6_pend !== m6.pend[5:0]) begin fails++; $display("FAIL rnd6_pend c=%0d: got %0h want %0h", c, o6_pend, m6.pend[5:0]); end
      if ($urandom_range(0, 39) == 0) heavy = !heavy;
      weight    = heavy ? 11'($urandom_range(900, 2047)) : 11'($urandom_range(0, 899));
      req_valid = ($urandom_range(0, 3) == 0);
      req_floor = 3'($urandom_range(0, 7));
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_sweep();
    test_overweight();
    test_same_floor();
    test_bounds();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
